// File: rtl/sfi_req_arb.sv
// sfi_req_arb: round-robin, packet-locking request arbiter for one SFI target port.
// Merges nSRC master request streams without interleaving packets. A 2-entry
// output FIFO decouples dst_ready from src_ready and sustains one beat per cycle.
module sfi_req_arb #(
  parameter int nSRC   = 4,
  parameter int DATA_W = 64,
  parameter int SRC_W  = $clog2(nSRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nSRC-1:0]        src_valid,
  output logic [nSRC-1:0]        src_ready,
  input  logic [nSRC*DATA_W-1:0] src_data,
  input  logic [nSRC-1:0]        src_last,
  output logic                   dst_valid,
  input  logic                   dst_ready,
  output logic [DATA_W-1:0]      dst_data,
  output logic                   dst_last,
  output logic [SRC_W-1:0]       dst_src,
  output logic [15:0]            pkt_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [SRC_W-1:0]   lock_src_q;
  logic [15:0]        pkt_cnt_q;

  // Output FIFO storage and pointers
  logic [DATA_W-1:0]  buf_data_q [2];
  logic               buf_last_q [2];
  logic [SRC_W-1:0]   buf_src_q  [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;

  logic [DATA_W-1:0]  src_data_arr [nSRC];
  logic [SRC_W-1:0]   win_idx;
  logic               win_found;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_ok;
  logic               push;
  logic               pop;
  logic               push_last;

  // Modulo-nSRC increment, valid for non-power-of-two source counts
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    if (i == SRC_W'(nSRC - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Unpack the flat source payload bus
  for (genvar gi = 0; gi < nSRC; gi++) begin : g_unpack
    assign src_data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
  end

  // IDLE winner: first valid source scanning upward from rr_ptr with wrap
  always_comb begin : p_winner
    logic [SRC_W-1:0] scan;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan      = rr_ptr_q;
    for (int k = 0; k < nSRC; k++) begin
      if (!win_found && src_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = next_idx(scan);
    end
  end

  // While locked only the packet owner may be granted, even if it bubbles
  assign grant_idx = (state_q == LOCKED) ? lock_src_q : win_idx;
  assign grant_ok  = (state_q == LOCKED) || win_found;

  // Ready depends only on registered state and src_valid, never on dst_ready
  always_comb begin
    src_ready = '0;
    if (!rst && (count_q != 2'd2) && grant_ok) src_ready[grant_idx] = 1'b1;
  end

  assign push      = src_valid[grant_idx] & src_ready[grant_idx];
  assign push_last = src_last[grant_idx];
  assign pop       = dst_valid & dst_ready;

  assign dst_valid = (count_q != 2'd0);
  assign dst_data  = buf_data_q[rd_ptr_q];
  assign dst_last  = buf_last_q[rd_ptr_q];
  assign dst_src   = buf_src_q[rd_ptr_q];
  assign pkt_cnt   = pkt_cnt_q;

  // Arbitration FSM: packet lock, round-robin pointer and packet counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_src_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (push && push_last) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (push && !push_last) begin
            state_q    <= LOCKED;
            lock_src_q <= grant_idx;
          end else if (push) begin
            rr_ptr_q <= next_idx(grant_idx);
          end
        end
        LOCKED: begin
          if (push && push_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_idx(lock_src_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO; head entry holds steady until popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 2; e++) begin
        buf_data_q[e] <= '0;
        buf_last_q[e] <= 1'b0;
        buf_src_q[e]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= src_data_arr[grant_idx];
        buf_last_q[wr_ptr_q] <= push_last;
        buf_src_q[wr_ptr_q]  <= grant_idx;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sfi_req_arb.sv
// Directed, table-driven bench for sfi_req_arb (nSRC=4, DATA_W=64).
// Source i drives payload (i<<8) + d, so expected dst_data encodes the source.
module tb_sfi_req_arb;

  localparam int NS = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_ready;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS-1:0]     src_last = '0;
  logic              dst_valid;
  logic              dst_ready = 1'b0;
  logic [DW-1:0]     dst_data;
  logic              dst_last;
  logic [1:0]        dst_src;
  logic [15:0]       pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sfi_req_arb #(.nSRC(NS), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .dst_last(dst_last), .dst_src(dst_src), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        seg;
    logic [3:0]  sv;
    logic [3:0]  sl;
    logic        dr;
    logic [7:0]  d;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_last;
    logic [1:0]  e_src;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic seg, input logic [3:0] sv, input logic [3:0] sl,
                              input logic dr, input logic [7:0] d, input logic [3:0] e_rdy,
                              input logic e_vld, input logic [63:0] e_data, input logic e_last,
                              input logic [1:0] e_src, input logic [15:0] e_cnt);
    vec_t v;
    v.seg = seg; v.sv = sv; v.sl = sl; v.dr = dr; v.d = d;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_last = e_last;
    v.e_src = e_src; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sv, input logic [3:0] sl, input logic dr, input logic [7:0] d);
    src_valid = sv;
    src_last  = sl;
    dst_ready = dr;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = 64'(d) + (64'(i) << 8);
  endtask

  // Reset entered and left away from the clock edge; ends at posedge+1
  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Single source, 3-beat packet
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 1, 8'h11, 4'b0001, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'h22, 4'b0001, 1, 64'h011, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h33, 4'b0001, 1, 64'h022, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 64'h033, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 64'h000, 0, 0, 1));
    // Fairness: all valid single-beat packets, then skip of idle sources
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 8'hA0, 4'b0001, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'hA1, 4'b0010, 1, 64'h0A0, 1, 0, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'hA2, 4'b0100, 1, 64'h1A1, 1, 1, 2));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'hA3, 4'b1000, 1, 64'h2A2, 1, 2, 3));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'hA4, 4'b0001, 1, 64'h3A3, 1, 3, 4));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 8'hA5, 4'b0010, 1, 64'h0A4, 1, 0, 5));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 64'h1A5, 1, 1, 6));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 8'hB0, 4'b1000, 0, 64'h000, 0, 0, 6));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 8'hB1, 4'b0001, 1, 64'h3B0, 1, 3, 7));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 64'h0B1, 1, 0, 8));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 64'h000, 0, 0, 8));
    // Lock: src1 4-beat packet with 2-cycle gap while src2 waits
    vecs.push_back(mk(1, 4'b0110, 4'b0100, 1, 8'h10, 4'b0010, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0100, 1, 8'h11, 4'b0010, 1, 64'h110, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h12, 4'b0010, 1, 64'h111, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h12, 4'b0010, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0100, 1, 8'h13, 4'b0010, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0110, 4'b0110, 1, 8'h14, 4'b0010, 1, 64'h113, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h15, 4'b0100, 1, 64'h114, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 64'h215, 1, 2, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 64'h000, 0, 0, 2));
    // Backpressure: two beats buffered, ready drops, then drain in order
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 0, 8'h40, 4'b0001, 0, 64'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'h41, 4'b0001, 1, 64'h040, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'h42, 4'b0000, 1, 64'h040, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'h42, 4'b0000, 1, 64'h040, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'h42, 4'b0000, 1, 64'h040, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h42, 4'b0001, 1, 64'h041, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 1, 64'h042, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 64'h000, 0, 0, 1));

    // Reset state, with all sources requesting so ready must be held off by rst
    drive(4'b1111, 4'b1111, 1'b1, 8'h77);
    #2;
    chk("rst.src_ready", 64'(src_ready), 64'h0);
    chk("rst.dst_valid", 64'(dst_valid), 64'h0);
    chk("rst.dst_data",  dst_data,       64'h0);
    chk("rst.dst_last",  64'(dst_last),  64'h0);
    chk("rst.dst_src",   64'(dst_src),   64'h0);
    chk("rst.pkt_cnt",   64'(pkt_cnt),   64'h0);
    $display("reset: src_ready=%b dst_valid=%b pkt_cnt=%0d", src_ready, dst_valid, pkt_cnt);

    foreach (vecs[k]) begin
      if (vecs[k].seg) do_reset();
      drive(vecs[k].sv, vecs[k].sl, vecs[k].dr, vecs[k].d);
      #2;
      chk($sformatf("v%0d.src_ready", k), 64'(src_ready), 64'(vecs[k].e_rdy));
      chk($sformatf("v%0d.dst_valid", k), 64'(dst_valid), 64'(vecs[k].e_vld));
      chk($sformatf("v%0d.pkt_cnt", k),   64'(pkt_cnt),   64'(vecs[k].e_cnt));
      if (vecs[k].e_vld) begin
        chk($sformatf("v%0d.dst_data", k), dst_data,       vecs[k].e_data);
        chk($sformatf("v%0d.dst_last", k), 64'(dst_last),  64'(vecs[k].e_last));
        chk($sformatf("v%0d.dst_src", k),  64'(dst_src),   64'(vecs[k].e_src));
      end
      $display("vec %0d: src_valid=%b src_ready=%b dst_valid=%b dst_data=0x%0h dst_last=%b dst_src=%0d pkt_cnt=%0d",
               k, src_valid, src_ready, dst_valid, dst_data, dst_last, dst_src, pkt_cnt);
      @(posedge clk);
      #1;
    end

    // Reset mid-packet: src2 single beat, then src3 beat 1 fills the buffer
    do_reset();
    drive(4'b0100, 4'b0100, 1'b0, 8'h50);
    #2;
    chk("mid.src2_ready", 64'(src_ready), 64'b0100);
    @(posedge clk); #1;
    drive(4'b1000, 4'b0000, 1'b0, 8'h51);
    #2;
    chk("mid.src3_ready", 64'(src_ready), 64'b1000);
    @(posedge clk); #1;
    drive(4'b1000, 4'b0000, 1'b0, 8'h52);
    #2;
    chk("mid.full_ready", 64'(src_ready), 64'h0);
    chk("mid.full_valid", 64'(dst_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid.rst_valid", 64'(dst_valid), 64'h0);
    chk("mid.rst_ready", 64'(src_ready), 64'h0);
    chk("mid.rst_cnt",   64'(pkt_cnt),   64'h0);
    $display("mid-packet reset: dst_valid=%b src_ready=%b", dst_valid, src_ready);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b1001, 4'b1001, 1'b1, 8'h53);
    #2;
    chk("mid.after_ready", 64'(src_ready), 64'b0001);
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 1'b1, 8'h00);
    #1;
    chk("mid.after_data", dst_data,      64'h053);
    chk("mid.after_src",  64'(dst_src),  64'h0);
    $display("after reset: dst_data=0x%0h dst_src=%0d", dst_data, dst_src);
    @(posedge clk); #1;

    // Counter wrap: 65535 single-beat packets, then one more
    do_reset();
    drive(4'b1111, 4'b1111, 1'b1, 8'h00);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap.ffff", 64'(pkt_cnt), 64'hFFFF);
    $display("wrap: pkt_cnt=0x%0h", pkt_cnt);
    @(posedge clk);
    #1;
    drive(4'b0000, 4'b0000, 1'b1, 8'h00);
    chk("wrap.zero", 64'(pkt_cnt), 64'h0);
    $display("wrap: pkt_cnt=0x%0h", pkt_cnt);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap.drained", 64'(dst_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
